konnect_slave_n: RTL
====================

KONNECT_SLAVE_N -- requirements
Module: konnect_slave_n

Interface
REQ-001 SHALL have parameter ADDR, default 4'hF, Konnect board address compared against bus nibble [3:0].
REQ-002 SHALL have parameter N_OUT, default 2, host-to-board byte count (1..8).
REQ-003 SHALL have parameter N_IN, default 4, board-to-host byte count (1..8).
REQ-004 fpga_clk  in  1  single system clock; all state on its rising edge.
REQ-005 kreset  in  1  asynchronous active-low reset.
REQ-006 k_clk  in  1  Konnect bus clock, asynchronous to fpga_clk.
REQ-007 start_in  in  1  Konnect transaction strobe, asynchronous.
REQ-008 kdata_in  in  8  bus data from pad buffer O pin.
REQ-009 k_in  in  8*N_IN  board inputs returned to host; byte j = k_in[8j+7:8j].
REQ-010 kdata_out  out  8  bus data to pad buffer I pin.
REQ-011 kdata_oe  out  1  active-high drive enable; pad T = ~kdata_oe.
REQ-012 k_out  out  8*N_OUT  board outputs written by host; byte i = k_out[8i+7:8i].
REQ-013 selected  out  1  address matched for current transaction.
REQ-014 xfer_done  out  1  one-cycle pulse when the last write byte commits.
REQ-015 state_cnt  out  clog2(N_OUT+N_IN+2)  byte counter, test visibility.

Function
REQ-016 k_clk and start_in SHALL each pass a 2-flop synchronizer and edge detector; rise/fall pulses occur exactly 3 fpga_clk cycles after the pin edge.
REQ-017 Event priority in one cycle SHALL be: start_in rise > start_in fall > k_clk rise > k_clk fall; lower events that cycle are ignored.
REQ-018 start_in rise: state_cnt <= 0, selected <= 0, kdata_out <= 0.
REQ-019 start_in fall: selected <= (kdata_in[3:0] == ADDR); k_in snapshot register loaded in the same cycle (coherent read set).
REQ-020 k_clk rise with selected: state_cnt increments, saturating at N_OUT+N_IN+1 (no wrap).
REQ-021 k_clk fall with selected and 1 <= state_cnt <= N_OUT: kdata_in SHALL be stored into shadow byte (state_cnt-1).
REQ-022 When shadow byte N_OUT-1 is stored, all shadow bytes SHALL copy into k_out in the following cycle and xfer_done pulses that cycle; k_out never shows a partial update.
REQ-023 k_clk fall with selected and state_cnt == N_OUT+j, 0 <= j < N_IN: kdata_out <= snapshot byte j.
REQ-024 k_clk fall with selected and state_cnt outside the above ranges (0 or >= N_OUT+N_IN): kdata_out <= 8'h00, no register changes.
REQ-025 kdata_oe SHALL equal synchronized k_clk AND selected AND synchronized start_in low AND N_OUT+1 <= state_cnt <= N_OUT+N_IN, registered one cycle.
REQ-026 Transaction aborted by start_in rise before last write byte SHALL leave k_out unchanged and discard shadow bytes; no xfer_done.
REQ-027 Non-selected transactions SHALL never assert kdata_oe, change k_out, or pulse xfer_done.
REQ-028 k_in changes after start_in fall SHALL NOT affect returned bytes until next transaction.

Reset
REQ-029 kreset low SHALL immediately clear k_out, shadow, snapshot, kdata_out to 0, state_cnt to 0, selected/kdata_oe/xfer_done to 0, and synchronizer/edge flops to 0.
REQ-030 kreset assertion mid-transaction SHALL abort it; after release the block waits for a new start_in fall.
REQ-031 Edge detectors SHALL not report a spurious edge on the first cycle after reset release when inputs are already high.

Verification (ADDR=F, N_OUT=2, N_IN=4)
REQ-032 Address F, write 3C then A5, k_in=32'h77_11_AA_55 -> k_out=16'hA53C, one xfer_done, read bytes 55, AA, 11, 77 with kdata_oe high only during k_clk high of counts 3..6.
REQ-033 Address 7, same bus activity -> selected=0, kdata_oe never high, k_out unchanged.
REQ-034 start_in rise after first write byte 12 -> k_out holds prior 16'hA53C, no xfer_done.
REQ-035 k_in changes to 0 mid-read -> remaining bytes still from snapshot 77_11_AA_55.
REQ-036 12 k_clk pulses in one transaction -> state_cnt saturates at 7, kdata_out 00, kdata_oe low after count 6.
REQ-037 kreset low during count 4 -> all outputs 0 asynchronously; next full transaction behaves as REQ-032.

Source files
------------

// File: rtl/konnect_slave_n.sv
// Konnect bus slave: host writes N_OUT bytes to k_out and reads back N_IN bytes of k_in.
// k_clk and start_in are asynchronous and are synchronised into the fpga_clk domain.

module konnect_sync_edge (
  input  logic fpga_clk,
  input  logic kreset,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic       s1_q, s2_q, prev_q;
  logic [2:0] vld_pipe;

  // Edges are suppressed until prev_q holds a real sample, so a pin that is
  // already high at reset release does not look like a rising edge.
  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1_q     <= d_i;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = vld_pipe[2] &  s2_q & ~prev_q;
  assign fall_o = vld_pipe[2] & ~s2_q &  prev_q;
endmodule

module konnect_slave_n #(
  parameter logic [3:0] ADDR  = 4'hF,
  parameter int         N_OUT = 2,
  parameter int         N_IN  = 4
) (
  input  logic                               fpga_clk,
  input  logic                               kreset,
  input  logic                               k_clk,
  input  logic                               start_in,
  input  logic [7:0]                         kdata_in,
  input  logic [8*N_IN-1:0]                  k_in,
  output logic [7:0]                         kdata_out,
  output logic                               kdata_oe,
  output logic [8*N_OUT-1:0]                 k_out,
  output logic                               selected,
  output logic                               xfer_done,
  output logic [$clog2(N_OUT+N_IN+2)-1:0]    state_cnt
);
  localparam int CW = $clog2(N_OUT+N_IN+2);
  localparam logic [CW-1:0] CMAX = CW'(N_OUT+N_IN+1);

  // bit 1: start_in, bit 0: k_clk
  logic [1:0] pin, lvl, rise, fall;
  assign pin = {start_in, k_clk};

  konnect_sync_edge u_sync [1:0] (
    .fpga_clk (fpga_clk),
    .kreset   (kreset),
    .d_i      (pin),
    .lvl_o    (lvl),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  logic                     st_rise, st_fall, kc_rise, kc_fall;
  assign st_rise = rise[1];
  assign st_fall = fall[1];
  assign kc_rise = rise[0];
  assign kc_fall = fall[0];

  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sel_q, sel_d;
  logic [7:0]               kdo_q, kdo_d;
  logic [N_OUT-1:0][7:0]    shadow_q, shadow_d, kout_q, kout_d;
  logic [N_IN-1:0][7:0]     snap_q, snap_d;
  logic                     pend_q, pend_d, xdone_q, xdone_d, oe_q, oe_d;

  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      kdo_q    <= '0;
      shadow_q <= '0;
      kout_q   <= '0;
      snap_q   <= '0;
      pend_q   <= 1'b0;
      xdone_q  <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      kdo_q    <= kdo_d;
      shadow_q <= shadow_d;
      kout_q   <= kout_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      xdone_q  <= xdone_d;
      oe_q     <= oe_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    kdo_d    = kdo_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
    kout_d   = kout_q;
    pend_d   = 1'b0;
    xdone_d  = 1'b0;
    // Whole-word commit one cycle after the last write byte lands in shadow.
    if (pend_q) begin
      kout_d  = shadow_q;
      xdone_d = 1'b1;
    end
    if (st_rise) begin
      cnt_d    = '0;
      sel_d    = 1'b0;
      kdo_d    = '0;
      shadow_d = '0;
    end else if (st_fall) begin
      sel_d  = (kdata_in[3:0] == ADDR);
      snap_d = k_in;
    end else if (kc_rise) begin
      if (sel_q && cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
    end else if (kc_fall && sel_q) begin
      kdo_d = '0;
      for (int i = 0; i < N_OUT; i++)
        if (cnt_q == CW'(i+1)) shadow_d[i] = kdata_in;
      if (cnt_q == CW'(N_OUT)) pend_d = 1'b1;
      // Count N_OUT both stores the last write byte and stages read byte 0.
      for (int j = 0; j < N_IN; j++)
        if (cnt_q == CW'(N_OUT+j)) kdo_d = snap_q[j];
    end
  end

  assign oe_d = lvl[0] & sel_q & ~lvl[1] &
                (cnt_q >= CW'(N_OUT+1)) & (cnt_q <= CW'(N_OUT+N_IN));

  assign kdata_out = kdo_q;
  assign kdata_oe  = oe_q;
  assign k_out     = kout_q;
  assign selected  = sel_q;
  assign xfer_done = xdone_q;
  assign state_cnt = cnt_q;
endmodule
